// File: rtl/vx_arb_pkg.sv
// Shared types and helpers for the burst stream arbiter.
// rr_next_idx supports up to RR_MAXW requesters.
package vx_arb_pkg;

  localparam int RR_MAXW = 32;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Round-robin winner: first set bit of valid at ptr, ptr+1, ... modulo num.
  // Returns ptr unchanged when no bit is set.
  function automatic int unsigned rr_next_idx(input int unsigned ptr,
                                              input logic [RR_MAXW-1:0] valid,
                                              input int unsigned num);
    int unsigned idx;
    logic found;
    logic [RR_MAXW-1:0] shifted;
    rr_next_idx = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAXW; k++) begin
      if (k < num) begin
        idx = ptr + k;
        if (idx >= num) begin
          idx = idx - num;
        end else begin
          idx = idx;
        end
        shifted = valid >> idx;
        if (!found && shifted[0]) begin
          rr_next_idx = idx;
          found = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
  endfunction

endpackage

// File: rtl/vx_burst_stream_arbiter_if.sv
// Stream bundle between NUM_REQS producers, the arbiter and one consumer.
// slave: arbiter view; master: environment (producers + consumer) view.
interface vx_burst_stream_arbiter_if #(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 32,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) ();

  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0]       last_in;
  logic [NUM_REQS-1:0]       ready_in;
  logic                      valid_out;
  logic [DATAW-1:0]          data_out;
  logic                      last_out;
  logic [LOG_NUM_REQS-1:0]   sel_out;
  logic                      ready_out;
  logic                      burst_err;

  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, last_out, sel_out, burst_err
  );

  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, last_out, sel_out, burst_err
  );

endinterface

// File: rtl/vx_burst_stream_arbiter_skid_buffer.sv
// Two-entry skid buffer used as the optional registered output stage.
// Only present when VX_BURST_ARB_OUT_BUF_EN is defined.
`ifdef VX_BURST_ARB_OUT_BUF_EN
module vx_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // Storage, pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`endif

// File: rtl/vx_burst_stream_arbiter.sv
// Burst-granular round-robin arbiter: a winner keeps the output until its
// last beat is accepted; over-length bursts raise a sticky burst_err.
// Optional feature macro: VX_BURST_ARB_OUT_BUF_EN (registered output stage).
module vx_burst_stream_arbiter
  import vx_arb_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 32,
  parameter int MAX_BURST    = 16,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int CNTW         = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_burst_stream_arbiter_if.slave arb_if
);

  localparam logic [LOG_NUM_REQS-1:0] LAST_IDX = LOG_NUM_REQS'(NUM_REQS - 1);
  localparam logic [CNTW-1:0]         CNT_MAX  = CNTW'(MAX_BURST);
  localparam logic [CNTW-1:0]         CNT_WARN = CNTW'(MAX_BURST - 1);

  arb_state_e              r_state, w_state_nxt;
  logic [LOG_NUM_REQS-1:0] r_ptr, w_ptr_nxt;
  logic [LOG_NUM_REQS-1:0] r_owner, w_owner_nxt;
  logic [LOG_NUM_REQS-1:0] r_sel_hold;
  logic [LOG_NUM_REQS-1:0] w_sel, w_rr_sel;
  logic [CNTW-1:0]         r_cnt, w_cnt_nxt;
  logic                    r_burst_err, w_burst_err_nxt;
  logic                    w_valid_sel, w_last_sel, w_hs, w_in_ready;
  logic [DATAW-1:0]        w_data_sel;
  logic [NUM_REQS-1:0]     w_ready_in;

  function automatic logic [LOG_NUM_REQS-1:0] incr_idx(input logic [LOG_NUM_REQS-1:0] idx);
    if (idx == LAST_IDX) begin
      return '0;
    end else begin
      return idx + LOG_NUM_REQS'(1);
    end
  endfunction

  // State register: FSM, pointer, owner, beat counter, sticky error, idle sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_burst_err <= 1'b0;
      r_sel_hold  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_burst_err <= w_burst_err_nxt;
      r_sel_hold  <= w_sel;
    end
  end

  // Next state: everything advances only on an accepted beat.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_burst_err_nxt = r_burst_err;
    if (w_hs) begin
      if (w_last_sel) begin
        w_state_nxt = ARB_IDLE;
        w_ptr_nxt   = incr_idx(w_sel);
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ARB_LOCKED;
        w_owner_nxt = w_sel;
        if (r_state == ARB_IDLE) begin
          w_cnt_nxt = CNTW'(1);
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
        // The counter is 0 in IDLE, so MAX_BURST=1 flags any non-last beat.
        if (r_cnt == CNT_WARN) begin
          w_burst_err_nxt = 1'b1;
        end else begin
          w_burst_err_nxt = r_burst_err;
        end
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Output selection: locked owner, round-robin winner, or held index when idle.
  always_comb begin
    w_rr_sel = LOG_NUM_REQS'(rr_next_idx(32'(r_ptr), RR_MAXW'(arb_if.valid_in), NUM_REQS));
    if (NUM_REQS == 1) begin
      w_sel = '0;
    end else if (r_state == ARB_LOCKED) begin
      w_sel = r_owner;
    end else if (|arb_if.valid_in) begin
      w_sel = w_rr_sel;
    end else begin
      w_sel = r_sel_hold;
    end
    w_valid_sel = 1'b0;
    w_last_sel  = 1'b0;
    w_data_sel  = '0;
    w_ready_in  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_sel == LOG_NUM_REQS'(i)) begin
        w_valid_sel   = arb_if.valid_in[i] & ~reset;
        w_last_sel    = arb_if.last_in[i];
        w_data_sel    = arb_if.data_in[i*DATAW +: DATAW];
        w_ready_in[i] = w_in_ready & ~reset;
      end else begin
        w_ready_in[i] = 1'b0;
      end
    end
    w_hs = w_valid_sel & w_in_ready;
  end

  assign arb_if.ready_in  = w_ready_in;
  assign arb_if.burst_err = r_burst_err;

`ifdef VX_BURST_ARB_OUT_BUF_EN
  logic                                w_buf_ready;
  logic [DATAW+1+LOG_NUM_REQS-1:0]     w_buf_dout;

  vx_skid_buffer #(
    .W (DATAW + 1 + LOG_NUM_REQS)
  ) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_valid_sel),
    .i_data  ({w_data_sel, w_last_sel, w_sel}),
    .o_ready (w_buf_ready),
    .o_valid (arb_if.valid_out),
    .o_data  (w_buf_dout),
    .i_ready (arb_if.ready_out)
  );

  assign w_in_ready      = w_buf_ready;
  assign arb_if.data_out = w_buf_dout[DATAW+LOG_NUM_REQS -: DATAW];
  assign arb_if.last_out = w_buf_dout[LOG_NUM_REQS];
  assign arb_if.sel_out  = w_buf_dout[LOG_NUM_REQS-1:0];
`else
  assign w_in_ready       = arb_if.ready_out;
  assign arb_if.valid_out = w_valid_sel;
  assign arb_if.data_out  = w_data_sel;
  assign arb_if.last_out  = w_last_sel;
  assign arb_if.sel_out   = w_sel;
`endif

endmodule

// File: tb/tb_vx_burst_stream_arbiter.sv
// Directed bench for vx_burst_stream_arbiter (NUM_REQS=4, MAX_BURST=4).
module tb_vx_burst_stream_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vx_burst_stream_arbiter_if #(.NUM_REQS(4), .DATAW(32), .LOG_NUM_REQS(2)) arb_if ();

  vx_burst_stream_arbiter #(
    .NUM_REQS  (4),
    .DATAW     (32),
    .MAX_BURST (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (arb_if)
  );

  function automatic logic [31:0] dval(input int i);
    return 32'hA0A0_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs after the falling edge, settle, then the caller checks.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic ro);
    @(negedge clk);
    arb_if.valid_in  = v;
    arb_if.last_in   = l;
    arb_if.ready_out = ro;
    #1;
  endtask

  initial begin
    arb_if.valid_in  = 4'b0000;
    arb_if.last_in   = 4'b0000;
    arb_if.ready_out = 1'b0;
    arb_if.data_in   = {dval(3), dval(2), dval(1), dval(0)};
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(arb_if.valid_out), 32'd0);
    chk("rst_ready", 32'(arb_if.ready_in), 32'd0);
    chk("rst_err", 32'(arb_if.burst_err), 32'd0);
    chk("rst_sel", 32'(arb_if.sel_out), 32'd0);
    reset = 1'b0;

    // Single-beat round robin over all requesters.
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      chk("rr_sel", 32'(arb_if.sel_out), 32'(k % 4));
      chk("rr_ready", 32'(arb_if.ready_in), 32'd1 << (k % 4));
      chk("rr_data", arb_if.data_out, dval(k % 4));
    end

    // Move pointer to 1, then req1 sends a 3-beat burst with req0/req2 busy.
    drive(4'b0001, 4'b1111, 1'b1);
    chk("s2_pre_sel", 32'(arb_if.sel_out), 32'd0);
    for (int b = 0; b < 3; b++) begin
      drive(4'b0111, (b == 2) ? 4'b1111 : 4'b1101, 1'b1);
      chk("s2_burst_sel", 32'(arb_if.sel_out), 32'd1);
      chk("s2_burst_last", 32'(arb_if.last_out), (b == 2) ? 32'd1 : 32'd0);
    end
    drive(4'b0111, 4'b1111, 1'b1);
    chk("s2_next_sel", 32'(arb_if.sel_out), 32'd2);

    // Pointer now 3; lock on req2, then req2 drops for two cycles.
    drive(4'b0100, 4'b1011, 1'b1);
    chk("s3_lock_sel", 32'(arb_if.sel_out), 32'd2);
    for (int c = 0; c < 2; c++) begin
      drive(4'b0001, 4'b1011, 1'b1);
      chk("s3_stall_valid", 32'(arb_if.valid_out), 32'd0);
      chk("s3_stall_sel", 32'(arb_if.sel_out), 32'd2);
      chk("s3_stall_ready", 32'(arb_if.ready_in), 32'b0100);
    end
    drive(4'b0101, 4'b1111, 1'b1);
    chk("s3_end_valid", 32'(arb_if.valid_out), 32'd1);
    chk("s3_end_sel", 32'(arb_if.sel_out), 32'd2);
    chk("s3_end_last", 32'(arb_if.last_out), 32'd1);
    drive(4'b0101, 4'b1111, 1'b1);
    chk("s3_after_sel", 32'(arb_if.sel_out), 32'd0);

    // Pointer now 1; backpressure must freeze everything.
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      chk("s4_sel", 32'(arb_if.sel_out), 32'd1);
      chk("s4_valid", 32'(arb_if.valid_out), 32'd1);
      chk("s4_ready", 32'(arb_if.ready_in), 32'd0);
      chk("s4_data", arb_if.data_out, dval(1));
    end
    drive(4'b1111, 4'b1111, 1'b1);
    chk("s4_release_sel", 32'(arb_if.sel_out), 32'd1);
    chk("s4_release_ready", 32'(arb_if.ready_in), 32'b0010);

    // Pointer now 2; req3 sends 5 non-last beats then last (MAX_BURST=4).
    for (int b = 1; b <= 5; b++) begin
      drive(4'b1000, 4'b0000, 1'b1);
      chk("s5_sel", 32'(arb_if.sel_out), 32'd3);
      chk("s5_err", 32'(arb_if.burst_err), (b == 5) ? 32'd1 : 32'd0);
    end
    drive(4'b1000, 4'b1000, 1'b1);
    chk("s5_last_err", 32'(arb_if.burst_err), 32'd1);
    chk("s5_last_out", 32'(arb_if.last_out), 32'd1);
    drive(4'b0000, 4'b0000, 1'b1);
    chk("s5_idle_valid", 32'(arb_if.valid_out), 32'd0);
    chk("s5_idle_sel_hold", 32'(arb_if.sel_out), 32'd3);
    chk("s5_idle_err", 32'(arb_if.burst_err), 32'd1);

    // Pointer now 0; lock on req1, then reset mid-burst.
    drive(4'b0010, 4'b0000, 1'b1);
    chk("s6_lock_sel", 32'(arb_if.sel_out), 32'd1);
    drive(4'b0010, 4'b0000, 1'b1);
    chk("s6_locked_sel", 32'(arb_if.sel_out), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    arb_if.valid_in = 4'b1111;
    arb_if.last_in  = 4'b1111;
    #1;
    chk("s6_rst_valid", 32'(arb_if.valid_out), 32'd0);
    chk("s6_rst_ready", 32'(arb_if.ready_in), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("s6_post_sel", 32'(arb_if.sel_out), 32'd0);
    chk("s6_post_ready", 32'(arb_if.ready_in), 32'b0001);
    chk("s6_post_err", 32'(arb_if.burst_err), 32'd0);
    chk("s6_post_valid", 32'(arb_if.valid_out), 32'd1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
